// File: rtl/mantissa_normalizer_pkg.sv
// Shared FP datapath definitions: default mantissa/exponent widths and the
// normalizer FSM state type.
package fp_pkg;

  localparam int MW = 24;
  localparam int EW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage : fp_pkg

// File: rtl/mantissa_normalizer_if.sv
// Handshake bundle between the adder, the mantissa normalizer and the
// exponent-adjust stage. The master drives requests, the slave is the normalizer.
interface mantissa_normalizer_if
  import fp_pkg::*;
#(
  parameter int MW = fp_pkg::MW,
  parameter int EW = fp_pkg::EW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [MW:0]   mant_in;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] mant_out;
  logic [EW-1:0] expminus;
  logic          exp_inc;
  logic          zero;

  modport master (
    output in_valid, mant_in, out_ready,
    input  in_ready, out_valid, mant_out, expminus, exp_inc, zero
  );

  modport slave (
    input  in_valid, mant_in, out_ready,
    output in_ready, out_valid, mant_out, expminus, exp_inc, zero
  );

endinterface : mantissa_normalizer_if

// File: rtl/mantissa_normalizer_nibble_zero_detect.sv
// 4-bit all-zero detector used to decide when a 4-position left shift is safe.
module nibble_zero_detect (
  input  logic [3:0] nibble_i,
  output logic       zero_o
);

  assign zero_o = ~|nibble_i;

endmodule : nibble_zero_detect

// File: rtl/mantissa_normalizer.sv
// Sequential post-add mantissa normalizer (IDLE -> NORM -> DONE).
// Define NORM_FAST_SHIFT_EN to allow 4-position left shifts when the top nibble is zero.
module mantissa_normalizer
  import fp_pkg::*;
#(
  parameter int MW = fp_pkg::MW,
  parameter int EW = fp_pkg::EW
) (
  input  logic                  clk,
  input  logic                  rst,
  mantissa_normalizer_if.slave  io
);

  // The left-shift count must fit in EW bits.
  if (MW - 1 >= (1 << EW)) begin : g_bad_ew
    $error("mantissa_normalizer: EW too small for MW-1 left shifts");
  end

  norm_state_t   state_q, state_d;
  logic [MW:0]   work_q, work_d;
  logic [EW-1:0] count_q, count_d;
  logic [MW-1:0] mant_out_q, mant_out_d;
  logic          exp_inc_q, exp_inc_d;
  logic          zero_q, zero_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

`ifdef NORM_FAST_SHIFT_EN
  logic top_nibble_zero;

  if (MW < 5) begin : g_bad_mw
    $error("mantissa_normalizer: fast shift needs MW >= 5");
  end

  nibble_zero_detect u_top_nibble (
    .nibble_i (work_q[MW-1:MW-4]),
    .zero_o   (top_nibble_zero)
  );
`endif

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    mant_out_d  = mant_out_q;
    exp_inc_d   = exp_inc_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          work_d     = io.mant_in;
          count_d    = '0;
          exp_inc_d  = 1'b0;
          zero_d     = 1'b0;
          in_ready_d = 1'b0;
          state_d    = NORM;
        end
      end

      NORM: begin
        if (work_q[MW]) begin
          // Adder carry: one right shift, LSB discarded without sticky.
          mant_out_d  = work_q[MW:1];
          exp_inc_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (work_q == '0) begin
          mant_out_d  = '0;
          count_d     = '0;
          zero_d      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (work_q[MW-1]) begin
          mant_out_d  = work_q[MW-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef NORM_FAST_SHIFT_EN
        end else if (top_nibble_zero) begin
          // Leading one sits at or below MW-5, so a 4-step shift cannot overshoot.
          work_d  = {work_q[MW-4:0], 4'b0000};
          count_d = count_q + EW'(4);
`endif
        end else begin
          work_d  = {work_q[MW-1:0], 1'b0};
          count_d = count_q + EW'(1);
        end
      end

      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      count_q     <= '0;
      mant_out_q  <= '0;
      exp_inc_q   <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      count_q     <= count_d;
      mant_out_q  <= mant_out_d;
      exp_inc_q   <= exp_inc_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.mant_out  = mant_out_q;
  assign io.expminus  = count_q;
  assign io.exp_inc   = exp_inc_q;
  assign io.zero      = zero_q;

endmodule : mantissa_normalizer
